// File: rtl/reg_bank_wr.sv
// 32-entry MIPS general-purpose register file: one synchronous write port,
// two combinational read ports, hard-wired $zero and $sp reset value.
module reg_bank_wr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WriteReg != '0)) begin
            regs_d[WriteReg] = WriteData;
        end
        // entry 0 is constant zero; synthesis removes its flops
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: reads always see pre-edge state.
    assign ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    assign ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];

endmodule

// File: tb/tb_reg_bank_wr.sv
// Self-checking bench for reg_bank_wr: directed vector table, reset sweeps,
// and randomized traffic against an array-based reference model.
module tb_reg_bank_wr;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SP_IDX   = 29;
    localparam int SP_RESET = 227;

    logic              clk;
    logic              reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        chk_pre;
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;

    vec_t vecs [10];

    reg_bank_wr #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_RESET(SP_RESET)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RegWrite (RegWrite),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [4:0] w,
                              input logic [31:0] d);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = (i == SP_IDX) ? 32'(SP_RESET) : 32'h0;
        end else if (we && w != 5'd0) begin
            model[w] = d;
        end
    endtask

    task automatic apply_vec(input int n, input vec_t v);
        @(negedge clk);
        reset = v.rst; RegWrite = v.we; WriteReg = v.wreg; WriteData = v.wdata;
        ReadReg1 = v.rr1; ReadReg2 = v.rr2;
        #1;
        if (v.chk_pre) begin
            check($sformatf("vec%0d_pre_rd1", n), ReadData1, v.pre1);
            check($sformatf("vec%0d_pre_rd2", n), ReadData2, v.pre2);
        end
        @(posedge clk);
        model_edge(v.rst, v.we, v.wreg, v.wdata);
        #1;
        check($sformatf("vec%0d_post_rd1", n), ReadData1, v.post1);
        check($sformatf("vec%0d_post_rd2", n), ReadData2, v.post2);
    endtask

    task automatic sweep(input string tag);
        @(negedge clk);
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check($sformatf("%s_rd1_r%0d", tag, i), ReadData1, model_rd(5'(i)));
            check($sformatf("%s_rd2_r%0d", tag, 31 - i), ReadData2, model_rd(5'(31 - i)));
        end
    endtask

    task automatic rand_cycle(input int n);
        logic        rst, we;
        logic [4:0]  w, r1, r2;
        logic [31:0] d;
        rst = ($urandom_range(0, 39) == 0);
        we  = ($urandom_range(0, 3) != 0);
        w   = 5'($urandom_range(0, 31));
        d   = $urandom;
        r1  = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
        r2  = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
        @(negedge clk);
        reset = rst; RegWrite = we; WriteReg = w; WriteData = d;
        ReadReg1 = r1; ReadReg2 = r2;
        #1;
        check($sformatf("rnd%0d_pre_rd1", n), ReadData1, model_rd(r1));
        check($sformatf("rnd%0d_pre_rd2", n), ReadData2, model_rd(r2));
        @(posedge clk);
        model_edge(rst, we, w, d);
        #1;
        check($sformatf("rnd%0d_post_rd1", n), ReadData1, model_rd(r1));
        check($sformatf("rnd%0d_post_rd2", n), ReadData2, model_rd(r2));
    endtask

    initial begin
        //           rst  we  wreg   wdata          rr1    rr2  chk  pre1          pre2          post1         post2
        vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd29, 1'b0, 32'h0,        32'h0,        32'h0,        32'd227};
        vecs[1] = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9,  1'b1, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  1'b1, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 5'd31, 32'h10,       5'd31, 5'd8,  1'b1, 32'h0,        32'hDEADBEEF, 32'h10,       32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 5'd31, 32'h400,      5'd8,  5'd31, 1'b1, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 32'h400};
        vecs[5] = '{1'b0, 1'b1, 5'd5,  32'h1234,     5'd5,  5'd29, 1'b1, 32'h0,        32'd227,      32'h1234,     32'd227};
        vecs[6] = '{1'b0, 1'b1, 5'd29, 32'h80,       5'd5,  5'd29, 1'b1, 32'h1234,     32'd227,      32'h1234,     32'h80};
        vecs[7] = '{1'b1, 1'b1, 5'd5,  32'h9999,     5'd5,  5'd29, 1'b1, 32'h1234,     32'h80,       32'h0,        32'd227};
        vecs[8] = '{1'b0, 1'b0, 5'd12, 32'h55,       5'd12, 5'd8,  1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[9] = '{1'b0, 1'b1, 5'd12, 32'h77,       5'd12, 5'd12, 1'b1, 32'h0,        32'h0,        32'h77,       32'h77};

        reset = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        apply_vec(0, vecs[0]);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            #1;
            check($sformatf("reset_sweep_r%0d", i), ReadData1, (i == 29) ? 32'd227 : 32'h0);
        end

        for (int n = 1; n < 10; n++) begin
            apply_vec(n, vecs[n]);
            if (n == 2) sweep("zero_wr");
            if (n == 7) sweep("mid_reset");
        end
        sweep("after_table");

        for (int n = 0; n < 400; n++) rand_cycle(n);
        sweep("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
